key_led_pattern: RTL and testbench

Parametrised successor of the two-key LED blinker. Drives NUM_LED LEDs with selectable patterns and speeds controlled by two debounced push-buttons.
- key[0] press cycles the pattern mode.
- key[1] press cycles the step speed.
Sits between board key pins and LED pins, one per board.

---
 rtl/key_led_pattern_pkg.sv | 26 ++
 rtl/key_led_pattern_if.sv | 12 +
 rtl/key_led_pattern_debounce.sv | 53 +++++
 rtl/key_led_pattern.sv | 170 +++++++++++++++++
 tb/tb_key_led_pattern.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/key_led_pattern_pkg.sv
// Shared mode encoding and limits for the key-driven LED pattern block.
// KEY_LED_BREATH_EN adds the BREATH mode and moves the wrap point to it.
package key_led_pkg;

  typedef enum logic [2:0] {
    MODE_OFF    = 3'd0,
    MODE_ON     = 3'd1,
    MODE_BLINK  = 3'd2,
    MODE_RUN    = 3'd3,
    MODE_PING   = 3'd4,
    MODE_BREATH = 3'd5
  } mode_e;

  localparam int NUM_SPEED = 4;

`ifdef KEY_LED_BREATH_EN
  localparam mode_e MODE_LAST = MODE_BREATH;
`else
  localparam mode_e MODE_LAST = MODE_PING;
`endif

  function automatic mode_e nextMode(input mode_e m);
    return (m == MODE_LAST) ? MODE_OFF : mode_e'(m + 3'd1);
  endfunction

endpackage

// File: rtl/key_led_pattern_if.sv
// Board-side bundle: raw key pins in, LED drive and status out.
interface key_led_pattern_if #(
  parameter int NUM_LED = 4
);
  logic [1:0]         key;
  logic [NUM_LED-1:0] led;
  logic [2:0]         mode;
  logic [1:0]         speed;

  modport master (output key, input led, mode, speed);
  modport slave  (input key, output led, mode, speed);
endinterface

// File: rtl/key_led_pattern_debounce.sv
// One push-button: 2-flop synchroniser, debounce counter and a 1-cycle
// press pulse on the accepted released->pressed transition.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_i,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= key_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  // The level flips once the synced value has disagreed for DEBOUNCE_CYC
  // cycles beyond the first mismatch; only the falling flip is an event.
  always_comb begin
    stable_d = stable_q;
    press_d  = 1'b0;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYC)) begin
        stable_d = sync2_q;
        press_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/key_led_pattern.sv
// Two-key LED pattern generator: key[0] cycles the mode, key[1] the speed.
// Define KEY_LED_BREATH_EN to add the PWM BREATH mode.
module key_led_pattern
  import key_led_pkg::*;
#(
  parameter int NUM_LED      = 4,
  parameter int CNT_TICK     = 25_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input logic              sys_clk,
  input logic              sys_rst,
  key_led_pattern_if.slave bus
);

  localparam int                 TW  = $clog2(CNT_TICK);
  localparam logic [NUM_LED-1:0] ONE = NUM_LED'(1);

  logic               modePress, speedPress, tick;
  mode_e              mode_q, mode_d;
  logic [1:0]         speed_q, speed_d;
  logic [TW-1:0]      cnt_q, cnt_d, lastCnt;
  logic [31:0]        period;
  logic               load_q;
  logic [NUM_LED-1:0] led_q, led_d;
  logic               dir_q, dir_d;
`ifdef KEY_LED_BREATH_EN
  logic [7:0]         pwm_q, pwm_d, duty_q, duty_d;
  logic               dutyUp_q, dutyUp_d;
  logic [TW-1:0]      bdiv_q, bdiv_d, stepLast;
`endif

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .key_i(bus.key[0]), .press_o(modePress)
  );
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .key_i(bus.key[1]), .press_o(speedPress)
  );

  assign period  = 32'(CNT_TICK) >> speed_q;
  assign lastCnt = TW'(period - 32'd1);
  assign tick    = (cnt_q == lastCnt);
`ifdef KEY_LED_BREATH_EN
  assign stepLast = ((period >> 9) == 32'd0) ? '0 : TW'((period >> 9) - 32'd1);
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mode_q   <= MODE_OFF;
      speed_q  <= '0;
      cnt_q    <= '0;
      load_q   <= 1'b0;
      led_q    <= '0;
      dir_q    <= 1'b1;
`ifdef KEY_LED_BREATH_EN
      pwm_q    <= '0;
      duty_q   <= '0;
      dutyUp_q <= 1'b1;
      bdiv_q   <= '0;
`endif
    end else begin
      mode_q   <= mode_d;
      speed_q  <= speed_d;
      cnt_q    <= cnt_d;
      load_q   <= modePress;
      led_q    <= led_d;
      dir_q    <= dir_d;
`ifdef KEY_LED_BREATH_EN
      pwm_q    <= pwm_d;
      duty_q   <= duty_d;
      dutyUp_q <= dutyUp_d;
      bdiv_q   <= bdiv_d;
`endif
    end
  end

  // Any press restarts the step timer so the new mode/speed begins cleanly.
  always_comb begin
    mode_d  = modePress ? nextMode(mode_q) : mode_q;
    speed_d = speed_q + {1'b0, speedPress};
    cnt_d   = (modePress || speedPress || tick) ? '0 : cnt_q + TW'(1);
  end

  // load_q marks the cycle after a mode press, when the new mode seeds its pattern.
  always_comb begin
    led_d = led_q;
    dir_d = dir_q;
`ifdef KEY_LED_BREATH_EN
    pwm_d    = pwm_q;
    duty_d   = duty_q;
    dutyUp_d = dutyUp_q;
    bdiv_d   = bdiv_q;
`endif
    case (mode_q)
      MODE_OFF:   led_d = '0;
      MODE_ON:    led_d = '1;
      MODE_BLINK: begin
        if (load_q)    led_d = '1;
        else if (tick) led_d = ~led_q;
      end
      MODE_RUN: begin
        if (load_q)    led_d = ONE;
        else if (tick) led_d = (led_q << 1) | (led_q >> (NUM_LED - 1));
      end
      MODE_PING: begin
        if (load_q) begin
          led_d = ONE;
          dir_d = 1'b1;
        end else if (NUM_LED == 1) begin
          led_d = ONE;
        end else if (tick) begin
          if (dir_q) begin
            if (led_q[NUM_LED-1]) begin
              dir_d = 1'b0;
              led_d = led_q >> 1;
            end else begin
              led_d = led_q << 1;
            end
          end else begin
            if (led_q[0]) begin
              dir_d = 1'b1;
              led_d = led_q << 1;
            end else begin
              led_d = led_q >> 1;
            end
          end
        end
      end
`ifdef KEY_LED_BREATH_EN
      MODE_BREATH: begin
        if (load_q) begin
          led_d    = '0;
          pwm_d    = '0;
          duty_d   = '0;
          dutyUp_d = 1'b1;
          bdiv_d   = '0;
        end else begin
          led_d = {NUM_LED{pwm_q < duty_q}};
          pwm_d = pwm_q + 8'd1;
          if (bdiv_q == stepLast) begin
            bdiv_d = '0;
            if (dutyUp_q) begin
              if (duty_q == 8'd255) begin
                dutyUp_d = 1'b0;
                duty_d   = 8'd254;
              end else begin
                duty_d = duty_q + 8'd1;
              end
            end else begin
              if (duty_q == 8'd0) begin
                dutyUp_d = 1'b1;
                duty_d   = 8'd1;
              end else begin
                duty_d = duty_q - 8'd1;
              end
            end
          end else begin
            bdiv_d = bdiv_q + TW'(1);
          end
        end
      end
`endif
      default: led_d = '0;
    endcase
  end

  assign bus.led   = led_q;
  assign bus.mode  = mode_q;
  assign bus.speed = speed_q;

endmodule

// File: tb/tb_key_led_pattern.sv
// Randomised self-checking bench for key_led_pattern against an event-level
// reference model; honours KEY_LED_BREATH_EN when defined.
module tb_key_led_pattern;

  localparam int NLED = 4;
  localparam int CNT  = 16;
  localparam int DEB  = 4;
`ifdef KEY_LED_BREATH_EN
  localparam int LASTMODE = 5;
`else
  localparam int LASTMODE = 4;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;

  key_led_pattern_if #(.NUM_LED(NLED)) bus ();

  key_led_pattern #(.NUM_LED(NLED), .CNT_TICK(CNT), .DEBOUNCE_CYC(DEB)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus(bus)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int passes = 0;

  // Reference model: keys are abstracted as clean presses (>DEB low samples)
  // or short glitches; a press becomes an update 3 edges after its DEB+1th low sample.
  int              mMode, mSpeed, mK, mSteps, edgeN, breathEdge;
  bit              mLoad;
  logic [NLED-1:0] mLed;
  int              lowRun[2], highRun[2];
  bit              pressed[2];
  bit              ev0[int];
  bit              ev1[int];
  logic [1:0]      waveQ[$];

  function automatic int triWave(input int i);
    int r;
    r = i % 510;
    return (r <= 255) ? r : 510 - r;
  endfunction

  function automatic logic [NLED-1:0] patternFor(input int md, input int steps, input int j);
    logic [NLED-1:0] one;
    int q, pos;
    one = 1;
    case (md)
      1: return '1;
      2: return (steps % 2 == 0) ? '1 : '0;
      3: return one << (steps % NLED);
      4: begin
        if (NLED == 1) return one;
        q   = steps % (2 * NLED - 2);
        pos = (q < NLED) ? q : (2 * NLED - 2 - q);
        return one << pos;
      end
      5: begin
        if (j == 0) return '0;
        return (((j - 1) % 256) < triWave(j - 1)) ? '1 : '0;
      end
      default: return '0;
    endcase
  endfunction

  task automatic modelReset();
    mMode = 0; mSpeed = 0; mK = 0; mSteps = 0; mLoad = 0; mLed = '0; breathEdge = 0;
    ev0.delete();
    ev1.delete();
    for (int i = 0; i < 2; i++) begin
      lowRun[i] = 0; highRun[i] = DEB + 1; pressed[i] = 0;
    end
  endtask

  task automatic modelStep();
    int  period;
    bit  tick, m0, s0;
    edgeN++;
    if (sys_rst) begin
      modelReset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      if (bus.key[i] == 1'b0) begin
        lowRun[i]++;
        highRun[i] = 0;
        if (lowRun[i] == DEB + 1 && !pressed[i]) begin
          pressed[i] = 1;
          if (i == 0) ev0[edgeN + 3] = 1;
          else        ev1[edgeN + 3] = 1;
        end
      end else begin
        highRun[i]++;
        lowRun[i] = 0;
        if (highRun[i] >= DEB + 1) pressed[i] = 0;
      end
    end
    period = CNT >> mSpeed;
    tick   = (mK == period - 1);
    m0     = ev0.exists(edgeN);
    s0     = ev1.exists(edgeN);
    if (mLoad) begin
      mSteps = 0;
      breathEdge = edgeN;
    end else if (tick) begin
      mSteps++;
    end
    mLed  = patternFor(mMode, mSteps, edgeN - breathEdge);
    mLoad = m0;
    if (m0) mMode = (mMode == LASTMODE) ? 0 : mMode + 1;
    if (s0) mSpeed = (mSpeed + 1) % 4;
    mK = (m0 || s0 || tick) ? 0 : mK + 1;
  endtask

  task automatic stepCycle();
    @(posedge sys_clk);
    modelStep();
    @(negedge sys_clk);
  endtask

  task automatic pushKeys(input logic [1:0] v, input int n);
    repeat (n) waveQ.push_back(v);
  endtask

  task automatic test_reset();
    bus.key = 2'b11;
    #1 sys_rst = 1'b1;
    modelReset();
    #1;
    checks++;
    if ({bus.led, bus.mode, bus.speed} !== 9'd0)
      $display("[TB] FAIL reset_initial: led=%h mode=%0d speed=%0d want all zero", bus.led, bus.mode, bus.speed);
    else passes++;
    repeat (3) stepCycle();
    sys_rst = 1'b0;
    pushKeys(2'b10, 6); pushKeys(2'b11, 10);
    pushKeys(2'b10, 6); pushKeys(2'b11, 30);
    while (waveQ.size() > 0) begin
      bus.key = waveQ.pop_front();
      stepCycle();
      checks++;
      if ({bus.led, bus.mode, bus.speed} !== {mLed, 3'(mMode), 2'(mSpeed)})
        $display("[TB] FAIL reset_prerun: led=%h mode=%0d speed=%0d want led=%h mode=%0d speed=%0d",
                 bus.led, bus.mode, bus.speed, mLed, mMode, mSpeed);
      else passes++;
    end
    #2 sys_rst = 1'b1;
    modelReset();
    #1;
    checks++;
    if ({bus.led, bus.mode, bus.speed} !== 9'd0)
      $display("[TB] FAIL reset_midrun: led=%h mode=%0d speed=%0d want all zero", bus.led, bus.mode, bus.speed);
    else passes++;
    for (int c = 0; c < 3; c++) begin
      stepCycle();
      checks++;
      if ({bus.led, bus.mode, bus.speed} !== 9'd0)
        $display("[TB] FAIL reset_hold: led=%h mode=%0d speed=%0d want all zero", bus.led, bus.mode, bus.speed);
      else passes++;
    end
    sys_rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      stepCycle();
      checks++;
      if ({bus.led, bus.mode, bus.speed} !== 9'd0)
        $display("[TB] FAIL reset_after: led=%h mode=%0d speed=%0d want all zero", bus.led, bus.mode, bus.speed);
      else passes++;
    end
  endtask

  task automatic test_glitch_press();
    pushKeys(2'b10, 2); pushKeys(2'b11, 12);
    while (waveQ.size() > 0) begin
      bus.key = waveQ.pop_front();
      stepCycle();
      checks++;
      if (bus.mode !== 3'd0 || bus.led !== mLed)
        $display("[TB] FAIL glitch: mode=%0d led=%h want mode=0 led=%h", bus.mode, bus.led, mLed);
      else passes++;
    end
    for (int c = 1; c <= 22; c++) begin
      bus.key = (c <= 10) ? 2'b10 : 2'b11;
      stepCycle();
      checks++;
      if ({bus.led, bus.mode, bus.speed} !== {mLed, 3'(mMode), 2'(mSpeed)})
        $display("[TB] FAIL press_model: c=%0d led=%h mode=%0d want led=%h mode=%0d", c, bus.led, bus.mode, mLed, mMode);
      else passes++;
      if (c == 7 || c == 8) begin
        checks++;
        if (bus.mode !== ((c == 8) ? 3'd1 : 3'd0))
          $display("[TB] FAIL press_latency: edge %0d mode=%0d want %0d", c, bus.mode, (c == 8) ? 1 : 0);
        else passes++;
      end
      if (c == 9) begin
        checks++;
        if (bus.led !== 4'hF)
          $display("[TB] FAIL press_on_led: led=%h want f", bus.led);
        else passes++;
      end
    end
  endtask

  task automatic test_run();
    for (int p = 0; p < 2; p++) begin pushKeys(2'b10, 6); pushKeys(2'b11, 10); end
    pushKeys(2'b11, 70);
    pushKeys(2'b01, 6); pushKeys(2'b11, 40);
    while (waveQ.size() > 0) begin
      bus.key = waveQ.pop_front();
      stepCycle();
      checks++;
      if ({bus.led, bus.mode, bus.speed} !== {mLed, 3'(mMode), 2'(mSpeed)})
        $display("[TB] FAIL run: led=%h mode=%0d speed=%0d want led=%h mode=%0d speed=%0d",
                 bus.led, bus.mode, bus.speed, mLed, mMode, mSpeed);
      else passes++;
    end
    checks++;
    if (bus.mode !== 3'd3 || bus.speed !== 2'd1)
      $display("[TB] FAIL run_state: mode=%0d speed=%0d want mode=3 speed=1", bus.mode, bus.speed);
    else passes++;
  endtask

  task automatic test_pingpong();
    pushKeys(2'b10, 6); pushKeys(2'b11, 10);
    for (int p = 0; p < 2; p++) begin pushKeys(2'b01, 6); pushKeys(2'b11, 10); end
    pushKeys(2'b11, 24);
    while (waveQ.size() > 0) begin
      bus.key = waveQ.pop_front();
      stepCycle();
      checks++;
      if ({bus.led, bus.mode, bus.speed} !== {mLed, 3'(mMode), 2'(mSpeed)})
        $display("[TB] FAIL pingpong: led=%h mode=%0d speed=%0d want led=%h mode=%0d speed=%0d",
                 bus.led, bus.mode, bus.speed, mLed, mMode, mSpeed);
      else passes++;
    end
    checks++;
    if (bus.mode !== 3'd4 || bus.speed !== 2'd3)
      $display("[TB] FAIL pingpong_state: mode=%0d speed=%0d want mode=4 speed=3", bus.mode, bus.speed);
    else passes++;
  endtask

  task automatic test_back_to_back();
    pushKeys(2'b00, 6); pushKeys(2'b11, 14);
    while (waveQ.size() > 0) begin
      bus.key = waveQ.pop_front();
      stepCycle();
      checks++;
      if ({bus.led, bus.mode, bus.speed} !== {mLed, 3'(mMode), 2'(mSpeed)})
        $display("[TB] FAIL simultaneous: led=%h mode=%0d speed=%0d want led=%h mode=%0d speed=%0d",
                 bus.led, bus.mode, bus.speed, mLed, mMode, mSpeed);
      else passes++;
    end
    checks++;
    if (bus.mode !== ((LASTMODE == 5) ? 3'd5 : 3'd0) || bus.speed !== 2'd0)
      $display("[TB] FAIL simultaneous_state: mode=%0d speed=%0d want mode=%0d speed=0",
               bus.mode, bus.speed, (LASTMODE == 5) ? 5 : 0);
    else passes++;
  endtask

`ifdef KEY_LED_BREATH_EN
  task automatic test_breath();
    pushKeys(2'b11, 1100);
    while (waveQ.size() > 0) begin
      bus.key = waveQ.pop_front();
      stepCycle();
      checks++;
      if ({bus.led, bus.mode} !== {mLed, 3'(mMode)})
        $display("[TB] FAIL breath: led=%h mode=%0d want led=%h mode=%0d", bus.led, bus.mode, mLed, mMode);
      else passes++;
    end
  endtask
`endif

  task automatic test_random();
    int kind, len;
    for (int s = 0; s < 40; s++) begin
      kind = $urandom_range(0, 4);
      len  = $urandom_range(DEB + 1, DEB + 6);
      case (kind)
        0: pushKeys(2'b10, len);
        1: pushKeys(2'b01, len);
        2: pushKeys(2'b00, len);
        3: pushKeys(($urandom_range(0, 1) == 0) ? 2'b10 : 2'b01, $urandom_range(1, DEB - 1));
        default: ;
      endcase
      pushKeys(2'b11, $urandom_range(DEB + 4, DEB + 12) + $urandom_range(0, 30));
    end
    while (waveQ.size() > 0) begin
      bus.key = waveQ.pop_front();
      stepCycle();
      checks++;
      if ({bus.led, bus.mode, bus.speed} !== {mLed, 3'(mMode), 2'(mSpeed)})
        $display("[TB] FAIL random: led=%h mode=%0d speed=%0d want led=%h mode=%0d speed=%0d",
                 bus.led, bus.mode, bus.speed, mLed, mMode, mSpeed);
      else passes++;
    end
  endtask

  initial begin
    edgeN = 0;
    modelReset();
    bus.key = 2'b11;
    test_reset();
    test_glitch_press();
    test_run();
    test_pingpong();
    test_back_to_back();
`ifdef KEY_LED_BREATH_EN
    test_breath();
`endif
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
